// File: rtl/pwm_bank_if.sv
// pwm_bank_if
//   Command bus between the SPI command decoder and the PWM bank.
//   cmd_data  : {addr, value} word, held stable until the next word completes
//   cmd_valid : word-complete flag, asynchronous to the PWM clock
//   cmd_err   : one-cycle pulse back from the bank on an unmapped address
//   master modport is the command source, slave modport is the PWM bank.
interface pwm_bank_if #(
    parameter int CMD_WIDTH = 24
);
    logic [CMD_WIDTH-1:0] cmd_data;
    logic                 cmd_valid;
    logic                 cmd_err;

    modport master (output cmd_data, output cmd_valid, input cmd_err);
    modport slave  (input cmd_data, input cmd_valid, output cmd_err);
endinterface

// File: rtl/pwm_bank.sv
// pwm_bank
//   Multi-channel PWM generator programmed by command words. All channels
//   share one programmable-period counter; per-channel thresholds are double
//   buffered (shadow -> active at period wrap) so updates never glitch.
// Ports
//   clk          : system clock
//   nreset       : asynchronous active-low reset
//   cmd          : command bus (slave side): cmd_data/cmd_valid in, cmd_err out
//   pwm_out      : registered PWM outputs, bit i inverted when POLARITY[i]=1
//   period_start : one-cycle pulse in the cycle the counter restarts at 0
// Address map: 0..NUM_PWM-1 shadow threshold, all-ones-minus-one = top,
//   all-ones = control {load_now, enable}, anything else raises cmd_err.
module pwm_bank #(
    parameter int                 PWM_WIDTH = 16,
    parameter int                 NUM_PWM   = 4,
    parameter int                 SEL_WIDTH = 8,
    parameter logic [NUM_PWM-1:0] POLARITY  = '0
) (
    input  logic               clk,
    input  logic               nreset,
    pwm_bank_if.slave          cmd,
    output logic [NUM_PWM-1:0] pwm_out,
    output logic               period_start
);
    localparam int                   CMD_WIDTH = SEL_WIDTH + PWM_WIDTH;
    localparam logic [SEL_WIDTH-1:0] ADDR_CTRL = '1;
    localparam logic [SEL_WIDTH-1:0] ADDR_TOP  = ADDR_CTRL - SEL_WIDTH'(1);

    logic [CMD_WIDTH-1:0] cmd_word;
    logic [SEL_WIDTH-1:0] cmd_addr;
    logic [PWM_WIDTH-1:0] cmd_value;
    logic                 cmd_fire;
    logic                 restart;
    logic                 addr_hit;

    logic valid_meta_q, valid_meta_d;
    logic valid_sync_q, valid_sync_d;
    logic valid_prev_q, valid_prev_d;

    logic [PWM_WIDTH-1:0] shadow_q [NUM_PWM];
    logic [PWM_WIDTH-1:0] shadow_d [NUM_PWM];
    logic [PWM_WIDTH-1:0] active_q [NUM_PWM];
    logic [PWM_WIDTH-1:0] active_d [NUM_PWM];
    logic [PWM_WIDTH-1:0] top_q, top_d;
    logic [PWM_WIDTH-1:0] counter_q, counter_d;
    logic                 enable_q, enable_d;
    logic [NUM_PWM-1:0]   pwm_q, pwm_d;
    logic                 period_start_q, period_start_d;
    logic                 cmd_err_q, cmd_err_d;

    assign cmd_word     = cmd.cmd_data;
    assign cmd_addr     = cmd_word[CMD_WIDTH-1 -: SEL_WIDTH];
    assign cmd_value    = cmd_word[PWM_WIDTH-1:0];
    assign pwm_out      = pwm_q;
    assign period_start = period_start_q;
    assign cmd.cmd_err  = cmd_err_q;

    // cmd_valid crosses domains through two flops; the third flop only
    // remembers the previous synchronized level for rising-edge detection.
    // cmd_data is read directly in the detect cycle because the source holds
    // it stable until the next word completes.
    always_comb begin
        valid_meta_d   = cmd.cmd_valid;
        valid_sync_d   = valid_meta_q;
        valid_prev_d   = valid_sync_q;
        cmd_fire       = valid_sync_q & ~valid_prev_q;

        shadow_d       = shadow_q;
        active_d       = active_q;
        top_d          = top_q;
        enable_d       = enable_q;
        counter_d      = counter_q;
        period_start_d = 1'b0;
        cmd_err_d      = 1'b0;
        restart        = 1'b0;
        addr_hit       = 1'b0;

        if (cmd_fire) begin
            if (cmd_addr == ADDR_CTRL) begin
                enable_d = cmd_value[0];
                // load_now, or a fresh enable, restarts the period immediately
                restart  = cmd_value[1] | (cmd_value[0] & ~enable_q);
            end else if (cmd_addr == ADDR_TOP) begin
                top_d = cmd_value;
            end else begin
                for (int i = 0; i < NUM_PWM; i++) begin
                    if (cmd_addr == SEL_WIDTH'(i)) begin
                        shadow_d[i] = cmd_value;
                        addr_hit    = 1'b1;
                    end
                end
                cmd_err_d = ~addr_hit;
            end
        end

        // Wraps copy shadow_q (not shadow_d), so a shadow write landing on
        // the wrap edge only takes effect one period later. A top lowered
        // below the running count is not caught: the counter rolls over
        // through all-ones without a period_start.
        if (restart) begin
            counter_d      = '0;
            active_d       = shadow_q;
            period_start_d = 1'b1;
        end else if (!enable_d) begin
            counter_d = '0;
        end else if (counter_q == top_q) begin
            counter_d      = '0;
            active_d       = shadow_q;
            period_start_d = 1'b1;
        end else begin
            counter_d = counter_q + 1'b1;
        end

        for (int i = 0; i < NUM_PWM; i++) begin
            pwm_d[i] = (enable_q & (counter_q < active_q[i])) ^ POLARITY[i];
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            valid_meta_q   <= 1'b0;
            valid_sync_q   <= 1'b0;
            valid_prev_q   <= 1'b0;
            shadow_q       <= '{default: '0};
            active_q       <= '{default: '0};
            top_q          <= '1;
            counter_q      <= '0;
            enable_q       <= 1'b0;
            pwm_q          <= POLARITY;
            period_start_q <= 1'b0;
            cmd_err_q      <= 1'b0;
        end else begin
            valid_meta_q   <= valid_meta_d;
            valid_sync_q   <= valid_sync_d;
            valid_prev_q   <= valid_prev_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            top_q          <= top_d;
            counter_q      <= counter_d;
            enable_q       <= enable_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
            cmd_err_q      <= cmd_err_d;
        end
    end
endmodule
